// File: rtl/countdown_timer.sv
// Loadable down-counting timer with a one-cycle EXPIRED pulse on reaching zero.
// Define AUTO_RELOAD_EN to restart from the last loaded value on expiry (periodic mode).
module countdown_timer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VALUE,
  input  logic             EN,
  input  logic             ABORT,
  output logic [WIDTH-1:0] VALUE,
  output logic             BUSY,
  output logic             EXPIRED
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             expired_q, expired_d;

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Next-state logic; priority is LOAD > ABORT > enabled decrement.
  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    expired_d = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d  = reload_q;
`endif
    if (LOAD) begin
      value_d = LOAD_VALUE;
`ifdef AUTO_RELOAD_EN
      reload_d = LOAD_VALUE;
`endif
      // A zero load is a one-shot pulse even in periodic mode, so EXPIRED cannot stick.
      if (LOAD_VALUE != ZERO) begin
        state_d = RUN;
      end else begin
        state_d   = IDLE;
        expired_d = 1'b1;
      end
    end else if (ABORT && (state_q == RUN)) begin
      state_d = IDLE;
      value_d = ZERO;
    end else if (EN && (state_q == RUN)) begin
      if (value_q == ONE) begin
        expired_d = 1'b1;
`ifdef AUTO_RELOAD_EN
        value_d   = reload_q;
        state_d   = RUN;
`else
        value_d   = ZERO;
        state_d   = IDLE;
`endif
      end else begin
        value_d = value_q - ONE;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      value_q   <= ZERO;
      expired_q <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_q  <= ZERO;
`endif
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      expired_q <= expired_d;
`ifdef AUTO_RELOAD_EN
      reload_q  <= reload_d;
`endif
    end
  end

  assign VALUE   = value_q;
  assign BUSY    = (state_q == RUN);
  assign EXPIRED = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed plus randomized bench for countdown_timer against a counting model.
module tb_countdown_timer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         load;
  logic [W-1:0] load_value;
  logic         en;
  logic         abort;
  logic [W-1:0] value;
  logic         busy;
  logic         expired;

  int n_vec;
  int n_err;

  // Reference model: remaining count, running flag, last loaded count, pulse.
  int m_val;
  bit m_run;
  int m_rel;
  bit m_exp;

  countdown_timer #(.WIDTH(W)) dut (
    .CLK        (clk),
    .RST        (rst),
    .LOAD       (load),
    .LOAD_VALUE (load_value),
    .EN         (en),
    .ABORT      (abort),
    .VALUE      (value),
    .BUSY       (busy),
    .EXPIRED    (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_edge(input bit r, input bit ld, input int lv,
                                     input bit e, input bit ab);
    m_exp = 1'b0;
    if (r) begin
      m_val = 0;
      m_run = 1'b0;
      m_rel = 0;
    end else if (ld) begin
      m_val = lv;
      m_rel = lv;
      m_run = (lv != 0);
      m_exp = (lv == 0);
    end else if (ab) begin
      if (m_run) begin
        m_run = 1'b0;
        m_val = 0;
      end
    end else if (m_run && e) begin
      m_val = m_val - 1;
      if (m_val == 0) begin
        m_exp = 1'b1;
`ifdef AUTO_RELOAD_EN
        m_val = m_rel;
`else
        m_run = 1'b0;
`endif
      end
    end
  endfunction

  task automatic check(input string tag, input int obs, input int exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step(input bit r, input bit ld, input int lv, input bit e, input bit ab);
    rst        = r;
    load       = ld;
    load_value = W'(lv);
    en         = e;
    abort      = ab;
    @(posedge clk);
    model_edge(r, ld, lv, e, ab);
    #1;
    check("value",   int'(value),   m_val);
    check("busy",    int'(busy),    int'(m_run));
    check("expired", int'(expired), int'(m_exp));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_val = 0;
    m_run = 1'b0;
    m_rel = 0;
    m_exp = 1'b0;

    // 1: reset, then idle with EN high must not wrap
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);

    // 2: load 5, EN constant
    step(1'b0, 1'b1, 5, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);

    // 3: load 4, EN toggling
    step(1'b0, 1'b1, 4, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0, (i % 2) == 0, 1'b0);

    // 4: load 10, abort at 6, then LOAD+ABORT together
    step(1'b0, 1'b1, 10, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 3, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);

    // 5: zero load, then restart mid-count
    step(1'b0, 1'b1, 0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);

    // 6: load 3 free-running, then reset mid-count
    step(1'b0, 1'b1, 3, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);

    // maximum count: no carry, decrements from all-ones
    step(1'b0, 1'b1, (1 << W) - 1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit r;
      bit ld;
      bit ab;
      bit e;
      int lv;
      r  = ($urandom_range(0, 99) < 2);
      ld = ($urandom_range(0, 99) < 8);
      ab = ($urandom_range(0, 99) < 5);
      e  = ($urandom_range(0, 99) < 75);
      lv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, (1 << W) - 1))
                                       : int'($urandom_range(0, 6));
      step(r, ld, lv, e, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
